// File: rtl/memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// memory_arbiter_if : fetch, data and shared-memory buses of memory_arbiter
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface memory_arbiter_if;
  logic        IF_Req_i;
  logic [31:0] IF_Address_i;
  logic        IF_Grant_o;
  logic        IF_Valid_o;
  logic [31:0] IF_Data_o;

  logic        Mem_Read_i;
  logic        Mem_Write_i;
  logic [31:0] Mem_Address_i;
  logic [31:0] Mem_Write_Data_i;
  logic        Mem_Grant_o;
  logic        Mem_Valid_o;
  logic [31:0] Mem_Read_Data_o;

  logic        Ram_Req_o;
  logic        Ram_We_o;
  logic [31:0] Ram_Addr_o;
  logic [31:0] Ram_WData_o;
  logic        Ram_Ack_i;
  logic [31:0] Ram_RData_i;

  logic        Stall_o;

  modport slave (
    input  IF_Req_i, IF_Address_i,
    output IF_Grant_o, IF_Valid_o, IF_Data_o,
    input  Mem_Read_i, Mem_Write_i, Mem_Address_i, Mem_Write_Data_i,
    output Mem_Grant_o, Mem_Valid_o, Mem_Read_Data_o,
    output Ram_Req_o, Ram_We_o, Ram_Addr_o, Ram_WData_o,
    input  Ram_Ack_i, Ram_RData_i,
    output Stall_o
  );

  modport master (
    output IF_Req_i, IF_Address_i,
    input  IF_Grant_o, IF_Valid_o, IF_Data_o,
    output Mem_Read_i, Mem_Write_i, Mem_Address_i, Mem_Write_Data_i,
    input  Mem_Grant_o, Mem_Valid_o, Mem_Read_Data_o,
    input  Ram_Req_o, Ram_We_o, Ram_Addr_o, Ram_WData_o,
    output Ram_Ack_i, Ram_RData_i,
    input  Stall_o
  );
endinterface

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter : shares one memory port between instruction fetch and data
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module memory_arbiter #(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  memory_arbiter_if.slave bus
);

  localparam int C_CNT_W = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
  localparam logic [C_CNT_W-1:0] C_BURST_MAX = C_CNT_W'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IF_BUSY   = 2'd1,
    DATA_BUSY = 2'd2
  } state_t;

  state_t               state_q;
  logic [C_CNT_W-1:0]   burst_q;
  logic [C_CNT_W-1:0]   burst_d;
  logic                 ram_req_q;
  logic                 ram_we_q;
  logic [31:0]          ram_addr_q;
  logic [31:0]          ram_wdata_q;
  logic                 if_valid_q;
  logic                 mem_valid_q;
  logic [31:0]          if_data_q;
  logic [31:0]          mem_rdata_q;

  logic                 w_mem_req;
  logic                 w_if_win;
  logic                 w_mem_win;

  // Grants are decided in the IDLE cycle itself so a requester can drop its
  // request on the following edge; a fetch only wins once data has had its burst.
  always_comb begin
    w_mem_req = bus.Mem_Read_i | bus.Mem_Write_i;
    w_if_win  = 1'b0;
    w_mem_win = 1'b0;
    if (reset && (state_q == IDLE)) begin
      if (bus.IF_Req_i && (!w_mem_req || (burst_q == C_BURST_MAX))) begin
        w_if_win = 1'b1;
      end else if (w_mem_req) begin
        w_mem_win = 1'b1;
      end
    end

    burst_d = burst_q;
    if (w_if_win) begin
      burst_d = '0;
    end else if (w_mem_win) begin
      if (!bus.IF_Req_i) begin
        burst_d = '0;
      end else if (burst_q != C_BURST_MAX) begin
        burst_d = burst_q + C_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      burst_q     <= burst_d;
      case (state_q)
        IDLE: begin
          if (w_if_win) begin
            state_q    <= IF_BUSY;
            ram_req_q  <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= bus.IF_Address_i;
          end else if (w_mem_win) begin
            state_q     <= DATA_BUSY;
            ram_req_q   <= 1'b1;
            ram_we_q    <= bus.Mem_Write_i;
            ram_addr_q  <= bus.Mem_Address_i;
            ram_wdata_q <= bus.Mem_Write_Data_i;
          end
        end
        IF_BUSY: begin
          if (bus.Ram_Ack_i) begin
            if_data_q  <= bus.Ram_RData_i;
            if_valid_q <= 1'b1;
            ram_req_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            state_q    <= IDLE;
          end
        end
        DATA_BUSY: begin
          if (bus.Ram_Ack_i) begin
            // A store (including read+write together) returns no data.
            if (!ram_we_q) begin
              mem_rdata_q <= bus.Ram_RData_i;
            end
            mem_valid_q <= 1'b1;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          ram_req_q <= 1'b0;
          ram_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IF_Grant_o      = w_if_win;
  assign bus.Mem_Grant_o     = w_mem_win;
  assign bus.IF_Valid_o      = if_valid_q;
  assign bus.Mem_Valid_o     = mem_valid_q;
  assign bus.IF_Data_o       = if_data_q;
  assign bus.Mem_Read_Data_o = mem_rdata_q;
  assign bus.Ram_Req_o       = ram_req_q;
  assign bus.Ram_We_o        = ram_we_q;
  assign bus.Ram_Addr_o      = ram_addr_q;
  assign bus.Ram_WData_o     = ram_wdata_q;
  assign bus.Stall_o         = reset & ((bus.IF_Req_i & ~w_if_win) |
                                        (w_mem_req & ~w_mem_win) |
                                        (state_q == DATA_BUSY));

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter : scoreboard bench for memory_arbiter
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_memory_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  memory_arbiter_if bus();

  memory_arbiter #(.MAX_DATA_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] exp_if = '0;
  logic [31:0] exp_mem = '0;
  int          grant_log[$];
  int          grant_cyc[$];
  logic        chk_burst = 1'b0;
  int          exp_order[6] = '{2, 2, 2, 2, 1, 2};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_model(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h0000_0513;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: grant bookkeeping and scoreboard pops on Valid pulses.
  always @(negedge clk) begin
    if (chk_burst) check("burst_clr_on_fetch", 32'(dut.burst_q), 32'd0);
    chk_burst <= bus.IF_Grant_o;
    if (bus.IF_Grant_o || bus.Mem_Grant_o) begin
      check("one_grant", 32'(bus.IF_Grant_o & bus.Mem_Grant_o), 32'd0);
      grant_log.push_back(bus.IF_Grant_o ? 1 : 2);
      grant_cyc.push_back(cyc);
    end
    if (bus.IF_Valid_o) begin
      if (if_q.size() == 0) check("if_valid_unexpected", 32'(bus.IF_Valid_o), 32'd0);
      else                  check("if_data", bus.IF_Data_o, if_q.pop_front());
    end
    if (bus.Mem_Valid_o) begin
      if (mem_q.size() == 0) check("mem_valid_unexpected", 32'(bus.Mem_Valid_o), 32'd0);
      else                   check("mem_rdata", bus.Mem_Read_Data_o, mem_q.pop_front());
    end
  end

  task automatic fetch(input logic [31:0] a);
    bit got = 0;
    bus.IF_Req_i     = 1'b1;
    bus.IF_Address_i = a;
    for (int c = 0; c < 200 && !got; c++) begin
      #1;
      if (bus.IF_Grant_o) begin
        exp_if = ram_model(a);
        if_q.push_back(exp_if);
        got = 1;
      end
      sync();
    end
    bus.IF_Req_i = 1'b0;
    check("if_granted", 32'(got), 32'd1);
  endtask

  task automatic mem_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    bit got = 0;
    bus.Mem_Read_i       = rd;
    bus.Mem_Write_i      = wr;
    bus.Mem_Address_i    = a;
    bus.Mem_Write_Data_i = wd;
    for (int c = 0; c < 200 && !got; c++) begin
      #1;
      if (bus.Mem_Grant_o) begin
        if (!wr) exp_mem = ram_model(a);
        mem_q.push_back(exp_mem);
        got = 1;
      end
      sync();
    end
    bus.Mem_Read_i  = 1'b0;
    bus.Mem_Write_i = 1'b0;
    check("mem_granted", 32'(got), 32'd1);
  endtask

  // Memory model: acks the next access after lat cycles of Ram_Req_o.
  task automatic ram_respond(input int lat, input logic [31:0] a, input logic we,
                             input logic [31:0] wd, input int exp_stall);
    int c = 0;
    do begin
      @(posedge clk);
      #3;
      c++;
    end while (!bus.Ram_Req_o && c < 200);
    for (int k = 1; k <= lat; k++) begin
      check("ram_req", 32'(bus.Ram_Req_o), 32'd1);
      check("ram_addr", bus.Ram_Addr_o, a);
      check("ram_we", 32'(bus.Ram_We_o), 32'(we));
      if (we) check("ram_wdata", bus.Ram_WData_o, wd);
      if (exp_stall >= 0) check("stall_busy", 32'(bus.Stall_o), 32'(exp_stall));
      if (k == lat) begin
        bus.Ram_Ack_i   = 1'b1;
        bus.Ram_RData_i = ram_model(a);
      end
      @(posedge clk);
      #3;
    end
    bus.Ram_Ack_i   = 1'b0;
    bus.Ram_RData_i = $urandom;
    check("ram_req_drop", 32'(bus.Ram_Req_o), 32'd0);
    check("valid_pulse", 32'(bus.IF_Valid_o | bus.Mem_Valid_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.IF_Req_i = 0; bus.IF_Address_i = '0;
    bus.Mem_Read_i = 0; bus.Mem_Write_i = 0;
    bus.Mem_Address_i = '0; bus.Mem_Write_Data_i = '0;
    bus.Ram_Ack_i = 0; bus.Ram_RData_i = $urandom;

    // Reset state, with requests present to show grants are held off.
    repeat (2) sync();
    check("rst_bits", {25'b0, bus.Ram_Req_o, bus.Ram_We_o, bus.IF_Grant_o, bus.IF_Valid_o,
                       bus.Mem_Grant_o, bus.Mem_Valid_o, bus.Stall_o}, 32'd0);
    check("rst_if_data", bus.IF_Data_o, 32'd0);
    check("rst_mem_rdata", bus.Mem_Read_Data_o, 32'd0);
    check("rst_ram_addr", bus.Ram_Addr_o, 32'd0);
    check("rst_ram_wdata", bus.Ram_WData_o, 32'd0);
    bus.IF_Req_i = 1; bus.Mem_Read_i = 1;
    #1;
    check("rst_grant_gated", {30'b0, bus.IF_Grant_o, bus.Mem_Grant_o}, 32'd0);
    check("rst_stall", 32'(bus.Stall_o), 32'd0);
    bus.IF_Req_i = 0; bus.Mem_Read_i = 0;
    sync();
    reset = 1;
    sync();

    // Single fetch, ack three cycles after the grant.
    fork
      fetch(32'h0040_0000);
      ram_respond(3, 32'h0040_0000, 1'b0, 32'd0, 0);
    join
    sync();
    check("fetch_data_513", bus.IF_Data_o, 32'h0000_0513);

    // Contention: data first, fetch granted the cycle after the data ack.
    grant_log.delete(); grant_cyc.delete();
    fork
      fetch(32'h0040_0004);
      mem_op(1'b1, 1'b0, 32'h2000_0000, 32'd0);
      begin
        ram_respond(2, 32'h2000_0000, 1'b0, 32'd0, 1);
        ram_respond(1, 32'h0040_0004, 1'b0, 32'd0, 0);
      end
    join
    sync();
    check("cont_n_grants", grant_log.size(), 32'd2);
    if (grant_log.size() == 2) begin
      check("cont_first_data", grant_log[0], 32'd2);
      check("cont_then_fetch", grant_log[1], 32'd1);
      check("cont_fetch_gap", grant_cyc[1] - grant_cyc[0], 32'd3);
    end

    // Starvation limit: four data grants, then the waiting fetch.
    grant_log.delete(); grant_cyc.delete();
    fork
      fetch(32'h0040_0008);
      for (int i = 0; i < 5; i++) mem_op(1'b1, 1'b0, 32'h1000_0000 + 32'(4 * i), 32'd0);
      begin
        for (int i = 0; i < 4; i++) ram_respond(1, 32'h1000_0000 + 32'(4 * i), 1'b0, 32'd0, -1);
        ram_respond(1, 32'h0040_0008, 1'b0, 32'd0, -1);
        ram_respond(1, 32'h1000_0010, 1'b0, 32'd0, -1);
      end
    join
    sync();
    check("starve_n_grants", grant_log.size(), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) check("starve_order", grant_log[i], exp_order[i]);

    // Data request withdrawn while a fetch is busy issues nothing.
    grant_log.delete();
    fork
      fetch(32'h0040_000C);
      ram_respond(3, 32'h0040_000C, 1'b0, 32'd0, -1);
      begin
        sync(); bus.Mem_Read_i = 1; bus.Mem_Address_i = 32'h2000_0040;
        sync(); bus.Mem_Read_i = 0;
      end
    join
    for (int i = 0; i < 3; i++) begin
      sync();
      check("withdraw_no_req", 32'(bus.Ram_Req_o), 32'd0);
    end
    check("withdraw_grants", grant_log.size(), 32'd1);

    // Load, then stores: read data must survive the stores.
    fork
      mem_op(1'b1, 1'b0, 32'h1000_0100, 32'd0);
      ram_respond(2, 32'h1000_0100, 1'b0, 32'd0, 1);
    join
    fork
      mem_op(1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
      ram_respond(2, 32'h1001_0004, 1'b1, 32'hDEAD_BEEF, 1);
    join
    sync();
    check("store_rdata_kept", bus.Mem_Read_Data_o, exp_mem);
    fork
      mem_op(1'b1, 1'b1, 32'h1001_0008, 32'hCAFE_F00D);
      ram_respond(1, 32'h1001_0008, 1'b1, 32'hCAFE_F00D, 1);
    join
    sync();
    check("rdwr_rdata_kept", bus.Mem_Read_Data_o, exp_mem);

    // Reset while DATA_BUSY, ack arriving after release.
    bus.Mem_Read_i = 1; bus.Mem_Address_i = 32'h3000_0000;
    #1;
    check("rstmid_grant", 32'(bus.Mem_Grant_o), 32'd1);
    sync();
    bus.Mem_Read_i = 0;
    check("rstmid_busy", 32'(bus.Ram_Req_o & bus.Stall_o), 32'd1);
    reset = 0;
    sync();
    reset = 1;
    exp_if = '0; exp_mem = '0;
    check("rstmid_req_low", 32'(bus.Ram_Req_o), 32'd0);
    check("rstmid_rdata_clr", bus.Mem_Read_Data_o, 32'd0);
    bus.Ram_Ack_i = 1; bus.Ram_RData_i = 32'h1234_5678;
    sync();
    bus.Ram_Ack_i = 0;
    check("rstmid_late_ack", bus.Mem_Read_Data_o, 32'd0);
    check("rstmid_idle", 32'(dut.state_q), 32'd0);

    // Fresh accesses after reset, then a spurious ack in IDLE.
    fork
      fetch(32'h0040_0010);
      ram_respond(1, 32'h0040_0010, 1'b0, 32'd0, 0);
    join
    fork
      mem_op(1'b1, 1'b0, 32'h1000_0200, 32'd0);
      ram_respond(2, 32'h1000_0200, 1'b0, 32'd0, 1);
    join
    sync();
    bus.Ram_Ack_i = 1; bus.Ram_RData_i = 32'hFFFF_FFFF;
    sync();
    bus.Ram_Ack_i = 0;
    sync();
    check("spur_if_data", bus.IF_Data_o, exp_if);
    check("spur_mem_rdata", bus.Mem_Read_Data_o, exp_mem);
    check("spur_req", 32'(bus.Ram_Req_o), 32'd0);

    repeat (2) sync();
    check("if_sb_empty", if_q.size(), 32'd0);
    check("mem_sb_empty", mem_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
